// File: rtl/mem_stage_access_if.sv
// ----------------------------------------------------------------------------
// mem_stage_access_if
// Data-memory request/acknowledge bus between the MEM-stage access unit and
// the data memory.
//   mem_req    master->slave  request, held until mem_ack
//   mem_we     master->slave  1 = write access
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  write data
//   mem_ack    slave->master  one-cycle completion strobe
//   mem_rdata  slave->master  read data, valid with mem_ack
// ----------------------------------------------------------------------------
interface mem_stage_access_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_access.sv
// ----------------------------------------------------------------------------
// mem_stage_access
// MEM-stage access unit. Consumes the EX/MEM register outputs, performs
// word-only loads/stores over a req/ack bus and produces registered MEM/WB
// outputs. stall freezes upstream stages while an access is outstanding.
//
// Ports:
//   clk, rst (async, active-low)
//   PC, WB_En, MEM_R_En, MEM_W_En, dest, readdata, ALU_result : EX/MEM inputs
//   bus (mem_stage_access_if.master) : mem_req/mem_we/mem_addr/mem_wdata out,
//                                      mem_ack/mem_rdata in
//   stall          : combinational freeze request
//   PC_out, WB_En_out, MEM_R_En_out, dest_out, ALU_result_out, mem_data_out :
//                    registered MEM/WB copies
//   misalign       : one-cycle pulse, access with ALU_result[1:0] != 0
//   mem_err        : one-cycle pulse, access timed out
//
// Build option: define MEM_TIMEOUT_EN to abandon an access after TIMEOUT
// BUSY cycles without mem_ack. Without it BUSY waits forever and mem_err is 0.
// ----------------------------------------------------------------------------
module mem_stage_access #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] PC,
    input  logic              WB_En,
    input  logic              MEM_R_En,
    input  logic              MEM_W_En,
    input  logic [4:0]        dest,
    input  logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] ALU_result,
    mem_stage_access_if.master bus,
    output logic              stall,
    output logic [DATA_W-1:0] PC_out,
    output logic              WB_En_out,
    output logic              MEM_R_En_out,
    output logic [4:0]        dest_out,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              misalign,
    output logic              mem_err
);
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_r, state_s;
    logic              access_s, aligned_s, issue_s, done_s, timeout_s;
    logic              mem_req_r, mem_we_r;
    logic [DATA_W-1:0] mem_addr_r, mem_wdata_r;
    // Instruction held for the duration of an access
    logic [DATA_W-1:0] h_pc_r, h_alu_r;
    logic              h_wb_r, h_rd_r;
    logic [4:0]        h_dest_r;

    assign access_s  = MEM_R_En | MEM_W_En;
    assign aligned_s = (ALU_result[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    // Saturating count of BUSY cycles, cleared whenever idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_W'(TIMEOUT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The TIMEOUT-th BUSY cycle without ack abandons the access
    assign timeout_s = (state_r == BUSY) && !bus.mem_ack &&
                       (cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode plus issue/complete strobes
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s && aligned_s) begin
                    state_s = BUSY;
                    issue_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Gated by rst so stall reads 0 throughout reset, independent of inputs
    assign stall = rst & (issue_s | ((state_r == BUSY) & ~bus.mem_ack & ~timeout_s));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bus request registers and held instruction, captured on issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DATA_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            h_pc_r      <= {DATA_W{1'b0}};
            h_alu_r     <= {DATA_W{1'b0}};
            h_wb_r      <= 1'b0;
            h_rd_r      <= 1'b0;
            h_dest_r    <= 5'd0;
        end else if (issue_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= MEM_W_En;   // store wins when both enables are set
            mem_addr_r  <= ALU_result;
            mem_wdata_r <= readdata;
            h_pc_r      <= PC;
            h_alu_r     <= ALU_result;
            h_wb_r      <= WB_En;
            h_rd_r      <= MEM_R_En;
            h_dest_r    <= dest;
        end else if (done_s || timeout_s) begin
            mem_req_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_r;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

    // MEM/WB outputs: pass-through, bubbles, completion and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_out         <= {DATA_W{1'b0}};
            WB_En_out      <= 1'b0;
            MEM_R_En_out   <= 1'b0;
            dest_out       <= 5'd0;
            ALU_result_out <= {DATA_W{1'b0}};
            mem_data_out   <= {DATA_W{1'b0}};
            misalign       <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            misalign <= 1'b0;
            mem_err  <= timeout_s;
            case (state_r)
                IDLE: begin
                    PC_out         <= PC;
                    dest_out       <= dest;
                    ALU_result_out <= ALU_result;
                    // Any access suppresses writeback here: aligned ones
                    // bubble, misaligned ones are squashed
                    WB_En_out      <= access_s ? 1'b0 : WB_En;
                    MEM_R_En_out   <= (access_s && aligned_s) ? 1'b0 : MEM_R_En;
                    mem_data_out   <= {DATA_W{1'b0}};
                    misalign       <= access_s & ~aligned_s;
                end
                BUSY: begin
                    if (done_s) begin
                        PC_out         <= h_pc_r;
                        dest_out       <= h_dest_r;
                        ALU_result_out <= h_alu_r;
                        WB_En_out      <= h_wb_r;
                        MEM_R_En_out   <= h_rd_r;
                        mem_data_out   <= mem_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                    end else begin
                        WB_En_out      <= 1'b0;
                        MEM_R_En_out   <= 1'b0;
                        mem_data_out   <= {DATA_W{1'b0}};
                    end
                end
                default: begin
                    WB_En_out      <= 1'b0;
                    MEM_R_En_out   <= 1'b0;
                    mem_data_out   <= {DATA_W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_access.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_access
// Directed bench for mem_stage_access; the bench plays the memory slave.
// ----------------------------------------------------------------------------
module tb_mem_stage_access;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, readdata, ALU_result;
    logic        WB_En, MEM_R_En, MEM_W_En;
    logic [4:0]  dest;
    logic        stall, WB_En_out, MEM_R_En_out, misalign, mem_err;
    logic [31:0] PC_out, ALU_result_out, mem_data_out;
    logic [4:0]  dest_out;

    int checks = 0;
    int errors = 0;
    int stall_cnt;
    int req_cnt;

    mem_stage_access_if #(.DATA_W(32)) bus ();

    mem_stage_access #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .PC(PC), .WB_En(WB_En), .MEM_R_En(MEM_R_En),
        .MEM_W_En(MEM_W_En), .dest(dest), .readdata(readdata),
        .ALU_result(ALU_result), .bus(bus), .stall(stall), .PC_out(PC_out),
        .WB_En_out(WB_En_out), .MEM_R_En_out(MEM_R_En_out), .dest_out(dest_out),
        .ALU_result_out(ALU_result_out), .mem_data_out(mem_data_out),
        .misalign(misalign), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic wb, input logic rd,
                         input logic wr, input logic [4:0] d, input logic [31:0] alu,
                         input logic [31:0] wdata);
        PC = pc; WB_En = wb; MEM_R_En = rd; MEM_W_En = wr;
        dest = d; ALU_result = alu; readdata = wdata;
    endtask

    initial begin
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'd0;
        drive(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'h0);
        #12;
        // Reset: everything 0, stall forced low even with an access presented
        chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb", {31'd0, WB_En_out}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk); rst = 1'b1;

        // ALU op passes with one-cycle latency
        @(negedge clk);
        drive(32'h40, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
        #1; chk("alu_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("alu_wb", {31'd0, WB_En_out}, 32'd1);
        chk("alu_dest", {27'd0, dest_out}, 32'd5);
        chk("alu_res", ALU_result_out, 32'h1234);
        chk("alu_pc", PC_out, 32'h40);
        chk("alu_data", mem_data_out, 32'd0);

        // Load 0x100, ack in the fourth BUSY cycle
        drive(32'h44, 1'b1, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0);
        stall_cnt = 0;
        #1; if (stall) stall_cnt++;
        chk("ld_issue_stall", {31'd0, stall}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; end
            #1; if (stall) stall_cnt++;
            chk("ld_req", {31'd0, bus.mem_req}, 32'd1);
            chk("ld_addr", bus.mem_addr, 32'h100);
            chk("ld_we", {31'd0, bus.mem_we}, 32'd0);
            chk("ld_bubble", {31'd0, WB_En_out}, 32'd0);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        chk("ld_stall_cycles", stall_cnt, 32'd4);
        chk("ld_data", mem_data_out, 32'hDEADBEEF);
        chk("ld_wb", {31'd0, WB_En_out}, 32'd1);
        chk("ld_rd", {31'd0, MEM_R_En_out}, 32'd1);
        chk("ld_dest", {27'd0, dest_out}, 32'd7);
        chk("ld_pc", PC_out, 32'h44);
        chk("ld_req_drop", {31'd0, bus.mem_req}, 32'd0);

        // Ack while IDLE is ignored
        drive(32'h48, 1'b0, 1'b0, 1'b0, 5'd0, 32'h8, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        chk("idle_ack_req", {31'd0, bus.mem_req}, 32'd0);
        chk("idle_ack_data", mem_data_out, 32'd0);
        chk("idle_ack_alu", ALU_result_out, 32'h8);

        // Store 0x200, ack in the second BUSY cycle
        drive(32'h4C, 1'b0, 1'b0, 1'b1, 5'd0, 32'h200, 32'hA5A5A5A5);
        stall_cnt = 0;
        #1; if (stall) stall_cnt++;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678; end
            #1; if (stall) stall_cnt++;
            chk("st_we", {31'd0, bus.mem_we}, 32'd1);
            chk("st_wdata", bus.mem_wdata, 32'hA5A5A5A5);
            chk("st_addr", bus.mem_addr, 32'h200);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        chk("st_stall_cycles", stall_cnt, 32'd2);
        chk("st_data", mem_data_out, 32'd0);
        chk("st_req_drop", {31'd0, bus.mem_req}, 32'd0);

        // Load and store together: store wins, WB_En forwarded
        drive(32'h50, 1'b1, 1'b1, 1'b1, 5'd9, 32'h300, 32'h0BADF00D);
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
        #1;
        chk("both_we", {31'd0, bus.mem_we}, 32'd1);
        chk("both_ack_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        chk("both_wb", {31'd0, WB_En_out}, 32'd1);
        chk("both_data", mem_data_out, 32'd0);
        chk("both_dest", {27'd0, dest_out}, 32'd9);

        // Misaligned load: no bus access, one-cycle misalign pulse
        drive(32'h54, 1'b1, 1'b1, 1'b0, 5'd3, 32'h103, 32'h0);
        #1; chk("mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_wb", {31'd0, WB_En_out}, 32'd0);
        chk("mis_req", {31'd0, bus.mem_req}, 32'd0);
        chk("mis_alu", ALU_result_out, 32'h103);
        drive(32'h58, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

        // Reset asserted mid-BUSY
        drive(32'h5C, 1'b1, 1'b1, 1'b0, 5'd4, 32'h400, 32'h0);
        @(negedge clk);
        chk("rb_req", {31'd0, bus.mem_req}, 32'd1);
        chk("rb_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rb_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rb_stall_drop", {31'd0, stall}, 32'd0);
        chk("rb_alu_clr", ALU_result_out, 32'd0);
        chk("rb_pc_clr", PC_out, 32'd0);
        drive(32'h60, 1'b1, 1'b0, 1'b0, 5'd6, 32'h66, 32'h0);
        #2; rst = 1'b1;
        @(negedge clk);
        chk("rb_idle_wb", {31'd0, WB_En_out}, 32'd1);
        chk("rb_idle_alu", ALU_result_out, 32'h66);
        chk("rb_idle_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rb_err", {31'd0, mem_err}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: never ack, request abandoned after TIMEOUT BUSY cycles
        drive(32'h64, 1'b1, 1'b1, 1'b0, 5'd2, 32'h500, 32'h0);
        req_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) req_cnt++;
            chk("to_stall", {31'd0, stall}, (k == 4) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        chk("to_req_cycles", req_cnt, 32'd4);
        chk("to_err", {31'd0, mem_err}, 32'd1);
        chk("to_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("to_wb", {31'd0, WB_En_out}, 32'd0);
        chk("to_data", mem_data_out, 32'd0);
        drive(32'h68, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("to_err_end", {31'd0, mem_err}, 32'd0);
        chk("to_late_ack", mem_data_out, 32'd0);
`else
        req_cnt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
